// File: rtl/ripple_carry_adder_4b.sv
// Ripple-carry adder built from a chain of one-bit full adders, with a single
// registered output stage carrying sum, unsigned carry-out, signed overflow and valid.
module ripple_carry_adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] raw_sum;
    logic             raw_c_out;
    logic             carry_into_msb;

    logic [WIDTH-1:0] sum_d,       sum_q;
    logic             c_out_d,     c_out_q;
    logic             overflow_d,  overflow_q;
    logic             out_valid_d, out_valid_q;

    // The carry is walked LSB to MSB through one variable; the carry entering
    // the top stage is kept aside because signed overflow needs it.
    always_comb begin
        logic carry;
        carry          = c_in;
        raw_sum        = '0;
        carry_into_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                carry_into_msb = carry;
            end
            raw_sum[i] = in_1[i] ^ in_2[i] ^ carry;
            carry      = (in_1[i] & in_2[i]) | (in_1[i] & carry) | (in_2[i] & carry);
        end
        raw_c_out = carry;
    end

    always_comb begin
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = raw_sum;
            c_out_d     = raw_c_out;
            overflow_d  = carry_into_msb ^ raw_c_out;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry_adder_4b.sv
// Directed and exhaustive checks of the 4-bit registered ripple-carry adder.
module tb_ripple_carry_adder_4b;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_1;
    logic [3:0] in_2;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;
    logic       overflow;
    logic       out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    ripple_carry_adder_4b #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_1      (in_1),
        .in_2      (in_2),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; results are sampled just after the next rising edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic ci);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_1     = a;
        in_2     = b;
        c_in     = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 4'b1011, 4'b0110, 1'b1);
        drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset: got v=%b c=%b ov=%b sum=%b, expected all zero",
                     out_valid, c_out, overflow, sum);
        end
    endtask

    // Each row: in_1, in_2, c_in, expected sum, c_out, overflow (hand computed).
    task automatic test_vectors();
        logic [11:0] vin  [8];
        logic [5:0]  vexp [8];
        vin[0] = {4'b0001, 4'b1111, 4'b0001}; vexp[0] = {4'b0001, 1'b1, 1'b0};
        vin[1] = {4'b1111, 4'b0001, 4'b0001}; vexp[1] = {4'b0001, 1'b1, 1'b0};
        vin[2] = {4'b0101, 4'b1101, 4'b0000}; vexp[2] = {4'b0010, 1'b1, 1'b0};
        vin[3] = {4'b1001, 4'b1011, 4'b0001}; vexp[3] = {4'b0101, 1'b1, 1'b1};
        vin[4] = {4'b0011, 4'b1101, 4'b0000}; vexp[4] = {4'b0000, 1'b1, 1'b0};
        vin[5] = {4'b1000, 4'b0100, 4'b0001}; vexp[5] = {4'b1101, 1'b0, 1'b0};
        vin[6] = {4'b0101, 4'b0011, 4'b0001}; vexp[6] = {4'b1001, 1'b0, 1'b1};
        vin[7] = {4'b0111, 4'b1011, 4'b0001}; vexp[7] = {4'b0011, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            logic [11:0] row;
            row = vin[i];
            drive(1'b0, 1'b1, row[11:8], row[7:4], row[0]);
            tests_run++;
            if ({sum, c_out, overflow, out_valid} !== {vexp[i], 1'b1}) begin
                tests_failed++;
                $display("[TB] FAIL vector%0d: got sum=%b c=%b ov=%b v=%b, expected sum=%b c=%b ov=%b v=1",
                         i, sum, c_out, overflow, out_valid, vexp[i][5:2], vexp[i][1], vexp[i][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 4'b0010, 4'b0011, 1'b0);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== {1'b1, 1'b0, 1'b0, 4'b0101}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_0: got v=%b c=%b ov=%b sum=%b, expected v=1 c=0 ov=0 sum=0101",
                     out_valid, c_out, overflow, sum);
        end
        drive(1'b0, 1'b1, 4'b1110, 4'b1100, 1'b1);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== {1'b1, 1'b1, 1'b0, 4'b1011}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_1: got v=%b c=%b ov=%b sum=%b, expected v=1 c=1 ov=0 sum=1011",
                     out_valid, c_out, overflow, sum);
        end
        drive(1'b0, 1'b1, 4'b0110, 4'b0110, 1'b0);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== {1'b1, 1'b0, 1'b1, 4'b1100}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_2: got v=%b c=%b ov=%b sum=%b, expected v=1 c=0 ov=1 sum=1100",
                     out_valid, c_out, overflow, sum);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 4'b1001, 4'b1011, 1'b1);
        drive(1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== {1'b0, 1'b1, 1'b1, 4'b0101}) begin
            tests_failed++;
            $display("[TB] FAIL hold_1: got v=%b c=%b ov=%b sum=%b, expected v=0 c=1 ov=1 sum=0101",
                     out_valid, c_out, overflow, sum);
        end
        drive(1'b0, 1'b0, 4'b0111, 4'b0111, 1'b1);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== {1'b0, 1'b1, 1'b1, 4'b0101}) begin
            tests_failed++;
            $display("[TB] FAIL hold_2: got v=%b c=%b ov=%b sum=%b, expected v=0 c=1 ov=1 sum=0101",
                     out_valid, c_out, overflow, sum);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0);
        drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: got v=%b c=%b ov=%b sum=%b, expected all zero",
                     out_valid, c_out, overflow, sum);
        end
        drive(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);
        tests_run++;
        if ({out_valid, c_out, overflow, sum} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_discard: got v=%b c=%b ov=%b sum=%b, expected all zero",
                     out_valid, c_out, overflow, sum);
        end
    endtask

    // Reference: integer addition for {c_out,sum}; overflow when operands share a
    // sign that the result does not.
    task automatic test_exhaustive();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    logic [3:0] av, bv, es;
                    logic       ec, eo;
                    int         total;
                    av    = 4'(a);
                    bv    = 4'(b);
                    total = a + b + ci;
                    es    = 4'(total);
                    ec    = (total > 15);
                    eo    = (av[3] == bv[3]) && (es[3] != av[3]);
                    drive(1'b0, 1'b1, av, bv, 1'(ci));
                    tests_run++;
                    if ({out_valid, c_out, sum, overflow} !== {1'b1, ec, es, eo}) begin
                        tests_failed++;
                        $display("[TB] FAIL exh %b+%b+%0d: got v=%b c=%b sum=%b ov=%b, expected v=1 c=%b sum=%b ov=%b",
                                 av, bv, ci, out_valid, c_out, sum, overflow, ec, es, eo);
                    end
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_1     = '0;
        in_2     = '0;
        c_in     = 1'b0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
